display_controller: RTL and testbench
=====================================

DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 Parameter: TICK_DIV, default 5000000, number of clock cycles per animation/blink step (legal range >= 2).
REQ-002 Port: clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: carrega  input  1  load request; latches valor when asserted.
REQ-005 Port: valor  input  24  six hex digits; digit i = valor[4i+3:4i], i=0..5.
REQ-006 Port: girar  input  1  level request for the spinning-segment "busy" animation.
REQ-007 Port: piscar  input  1  level request to blink the displayed value.
REQ-008 Port: apagar  input  1  level request to blank all displays.
REQ-009 Port: cod0..cod5  output  5 each  registered 5-bit codes, one per hexa7seg decoder instance (HEX0..HEX5).
REQ-010 Port: estado  output  2  current state (debug): 00 APAGADO, 01 MOSTRA, 10 GIRA.

Function
REQ-011 The block SHALL be a 3-state FSM (APAGADO, MOSTRA, GIRA); encoding 11 is illegal and SHALL recover to APAGADO on the next edge.
REQ-012 Transitions SHALL be evaluated every cycle with priority apagar > girar > carrega.
REQ-013 apagar=1: next state APAGADO from any state.
REQ-014 apagar=0, girar=1: next state GIRA; on entry from another state the phase fase SHALL be 0.
REQ-015 apagar=0, girar=0, carrega=1: valor SHALL be latched into valor_reg, flag valido set to 1, and next state MOSTRA (from any state).
REQ-016 carrega=1 with girar=1 and apagar=0: valor SHALL still be latched and valido set; state stays/goes GIRA.
REQ-017 carrega=1 with apagar=1: valor SHALL NOT be latched.
REQ-018 GIRA with girar=0 and carrega=0: next state MOSTRA if valido=1, else APAGADO.
REQ-019 APAGADO and MOSTRA with no request asserted: state held.
REQ-020 A tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserts in the cycle the count equals TICK_DIV-1; the counter SHALL be cleared on every state change, so the first step occurs TICK_DIV cycles after state entry.
REQ-021 GIRA: all six codes SHALL equal 5'h10 + fase; fase SHALL increment on each tick, wrapping 5 -> 0 (codes 5'h10..5'h15, one segment lit, rotating 0..5).
REQ-022 MOSTRA: cod_i SHALL be {1'b0, valor_reg digit i} while visivel=1, and 5'h1F while visivel=0.
REQ-023 visivel SHALL be set to 1 on MOSTRA entry and whenever piscar=0; with piscar=1 it SHALL toggle on each tick.
REQ-024 APAGADO: all codes SHALL be 5'h1F (decoder default = blank).
REQ-025 Outputs SHALL be registered: codes and estado reflect a request sampled at edge N from edge N onward (visible in the cycle after the input was sampled); no combinational input-to-output path.
REQ-026 valor_reg and valido SHALL be retained across GIRA and APAGADO.

Reset
REQ-027 reset=1 at a rising edge SHALL force: state APAGADO, estado=00, cod0..cod5=5'h1F, valor_reg=0, valido=0, fase=0, visivel=1, tick counter=0; reset overrides all other inputs, including mid-animation.

Verification (bench uses TICK_DIV=4)
REQ-028 Reset then idle 10 cycles -> estado=00, all codes 5'h1F throughout.
REQ-029 carrega pulse with valor=24'hABC123 -> next edge estado=01, cod0=03, cod1=02, cod2=01, cod3=0C, cod4=0B, cod5=0A; held with no further input.
REQ-030 girar held 30 cycles after load -> codes step 10,11,12,13,14,15,10 every 4 cycles, all digits equal; release girar -> MOSTRA with ABC123 restored.
REQ-031 girar asserted from reset (valido=0), then released -> returns to APAGADO, codes 5'h1F.
REQ-032 piscar=1 in MOSTRA -> codes alternate between value and 5'h1F every 4 cycles; piscar=0 -> value shown continuously from the next edge.
REQ-033 apagar+girar+carrega asserted together -> APAGADO, valor not latched; reset asserted mid-GIRA -> all outputs at reset values on that edge.

Source files
------------

// File: rtl/display_controller.sv
// Six-digit 7-segment display controller: shows a latched hex value, blinks it,
// blanks it, or runs a rotating single-segment "busy" animation on all digits.
module display_controller #(
  parameter int TICK_DIV = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        carrega,
  input  logic [23:0] valor,
  input  logic        girar,
  input  logic        piscar,
  input  logic        apagar,
  output logic [4:0]  cod0,
  output logic [4:0]  cod1,
  output logic [4:0]  cod2,
  output logic [4:0]  cod3,
  output logic [4:0]  cod4,
  output logic [4:0]  cod5,
  output logic [1:0]  estado
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] APAGADO = 2'b00;
  localparam logic [1:0] MOSTRA  = 2'b01;
  localparam logic [1:0] GIRA    = 2'b10;
  localparam logic [4:0] BLANK   = 5'h1F;

  logic [1:0]    state_q, state_d;
  logic [23:0]   valor_reg_q, valor_reg_d;
  logic          valido_q, valido_d;
  logic [2:0]    fase_q, fase_d;
  logic          visivel_q, visivel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    cod_q [6];
  logic [4:0]    cod_d [6];
  logic [1:0]    estado_q, estado_d;
  logic          tick_s;
  logic          changed_s;

  // State, datapath and registered output update
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= APAGADO;
      valor_reg_q <= 24'h000000;
      valido_q    <= 1'b0;
      fase_q      <= 3'd0;
      visivel_q   <= 1'b1;
      cnt_q       <= '0;
      estado_q    <= APAGADO;
      for (int i = 0; i < 6; i++) cod_q[i] <= BLANK;
    end else begin
      state_q     <= state_d;
      valor_reg_q <= valor_reg_d;
      valido_q    <= valido_d;
      fase_q      <= fase_d;
      visivel_q   <= visivel_d;
      cnt_q       <= cnt_d;
      estado_q    <= estado_d;
      for (int i = 0; i < 6; i++) cod_q[i] <= cod_d[i];
    end
  end

  // Next-state: request priority apagar > girar > carrega, plus tick/phase/blink
  always_comb begin
    state_d     = state_q;
    valor_reg_d = valor_reg_q;
    valido_d    = valido_q;
    fase_d      = fase_q;
    visivel_d   = visivel_q;
    tick_s      = (cnt_q == CW'(TICK_DIV - 1));

    if (!apagar && carrega) begin
      valor_reg_d = valor;
      valido_d    = 1'b1;
    end else begin
      valor_reg_d = valor_reg_q;
    end

    if (apagar) begin
      state_d = APAGADO;
    end else if (girar) begin
      state_d = GIRA;
    end else if (carrega) begin
      state_d = MOSTRA;
    end else begin
      case (state_q)
        GIRA:    state_d = valido_q ? MOSTRA : APAGADO;
        MOSTRA:  state_d = MOSTRA;
        APAGADO: state_d = APAGADO;
        default: state_d = APAGADO;
      endcase
    end
    // The unused encoding always falls back to blank, whatever is requested
    if (state_q == 2'b11) begin
      state_d = APAGADO;
    end else begin
      state_d = state_d;
    end

    changed_s = (state_d != state_q);
    if (changed_s || tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (state_d != GIRA || state_q != GIRA) begin
      fase_d = 3'd0;
    end else if (tick_s) begin
      fase_d = (fase_q == 3'd5) ? 3'd0 : fase_q + 3'd1;
    end else begin
      fase_d = fase_q;
    end

    if (state_d == MOSTRA && state_q != MOSTRA) begin
      visivel_d = 1'b1;
    end else if (!piscar) begin
      visivel_d = 1'b1;
    end else if (state_d == MOSTRA && tick_s) begin
      visivel_d = ~visivel_q;
    end else begin
      visivel_d = visivel_q;
    end
  end

  // Output codes computed from next-state values so they register on the same edge
  always_comb begin
    estado_d = state_d;
    for (int i = 0; i < 6; i++) begin
      case (state_d)
        GIRA:    cod_d[i] = 5'h10 + {2'b00, fase_d};
        MOSTRA:  cod_d[i] = visivel_d ? {1'b0, valor_reg_d[4*i +: 4]} : BLANK;
        APAGADO: cod_d[i] = BLANK;
        default: cod_d[i] = BLANK;
      endcase
    end
  end

  assign cod0   = cod_q[0];
  assign cod1   = cod_q[1];
  assign cod2   = cod_q[2];
  assign cod3   = cod_q[3];
  assign cod4   = cod_q[4];
  assign cod5   = cod_q[5];
  assign estado = estado_q;

endmodule

// File: tb/tb_display_controller.sv
// Directed self-checking bench for display_controller with TICK_DIV=4.
module tb_display_controller;

  logic        clock = 1'b0;
  logic        reset, carrega, girar, piscar, apagar;
  logic [23:0] valor;
  logic [4:0]  c0, c1, c2, c3, c4, c5;
  logic [1:0]  estado;
  int          total = 0;
  int          bad   = 0;

  display_controller #(.TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .carrega(carrega), .valor(valor),
    .girar(girar), .piscar(piscar), .apagar(apagar),
    .cod0(c0), .cod1(c1), .cod2(c2), .cod3(c3), .cod4(c4), .cod5(c5),
    .estado(estado)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] cod(input int i);
    case (i)
      0: return c0;
      1: return c1;
      2: return c2;
      3: return c3;
      4: return c4;
      default: return c5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [4:0] code);
    chk({tag, ".estado"}, {30'd0, estado}, {30'd0, st});
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s.cod%0d", tag, i), {27'd0, cod(i)}, {27'd0, code});
  endtask

  task automatic chk_val(input string tag, input logic [23:0] v);
    chk({tag, ".estado"}, {30'd0, estado}, 32'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s.cod%0d", tag, i), {27'd0, cod(i)}, {28'd0, v[4*i +: 4]});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; carrega = 1'b0; girar = 1'b0; piscar = 1'b0; apagar = 1'b0;
    valor = 24'h000000;
    cyc(2);
    chk_all("reset", 2'b00, 5'h1F);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk_all($sformatf("idle%0d", k), 2'b00, 5'h1F);
    end

    // load ABC123 and hold
    valor = 24'hABC123; carrega = 1'b1;
    cyc(1);
    carrega = 1'b0; valor = 24'h000000;
    chk_val("load", 24'hABC123);
    cyc(5);
    chk_val("hold", 24'hABC123);

    // spin for 30 cycles: phase steps every 4 cycles, wrapping after 5
    girar = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      chk_all($sformatf("gira%0d", k), 2'b10, 5'h10 + 5'((k / 4) % 6));
    end
    girar = 1'b0;
    cyc(1);
    chk_val("gira_rel", 24'hABC123);

    // blink: visible for edges 1..3, blank 4..7, visible 8..11, blank 12
    piscar = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (((k / 4) % 2) == 0) chk_val($sformatf("blink%0d", k), 24'hABC123);
      else chk_all($sformatf("blink%0d", k), 2'b01, 5'h1F);
    end
    piscar = 1'b0;
    cyc(1);
    chk_val("blink_off", 24'hABC123);
    cyc(3);
    chk_val("blink_off2", 24'hABC123);

    // spin with nothing loaded returns to blank
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_all("reset2", 2'b00, 5'h1F);
    girar = 1'b1;
    cyc(3);
    chk_all("gira_nv", 2'b10, 5'h10);
    girar = 1'b0;
    cyc(1);
    chk_all("gira_nv_rel", 2'b00, 5'h1F);

    // apagar overrides everything and blocks the latch
    valor = 24'h123456; carrega = 1'b1;
    cyc(1);
    carrega = 1'b0;
    chk_val("load2", 24'h123456);
    valor = 24'hFEDCBA; apagar = 1'b1; girar = 1'b1; carrega = 1'b1;
    cyc(1);
    chk_all("apagar_all", 2'b00, 5'h1F);
    apagar = 1'b0; carrega = 1'b0;
    cyc(1);
    chk_all("gira_after", 2'b10, 5'h10);
    girar = 1'b0;
    cyc(1);
    chk_val("no_latch", 24'h123456);

    // reset in the middle of the animation
    girar = 1'b1;
    cyc(6);
    chk_all("gira_mid", 2'b10, 5'h11);
    reset = 1'b1;
    cyc(1);
    chk_all("reset_mid", 2'b00, 5'h1F);
    reset = 1'b0; girar = 1'b0;
    cyc(1);
    chk_all("post_reset", 2'b00, 5'h1F);

    // carrega together with girar latches but stays spinning
    valor = 24'h0F0F0F; carrega = 1'b1; girar = 1'b1;
    cyc(1);
    chk_all("gira_load", 2'b10, 5'h10);
    carrega = 1'b0; girar = 1'b0; valor = 24'h000000;
    cyc(1);
    chk_val("gira_load_rel", 24'h0F0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
